// File: rtl/ofm_writeback.sv
// OFM writeback: buffers words pushed by post-processing in a FWFT FIFO and
// streams them to the DMA over AXI-Stream with a per-layer word budget.
module ofm_writeback #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_MARGIN  = 8,
    parameter int CNT_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_words,
    input  logic [DATA_W-1:0] ofm_buffer_data,
    input  logic              ofm_buffer_valid,
    output logic              almost_full,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_TH   = (AW+1)'(FIFO_DEPTH - AF_MARGIN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q;
    logic              busy_q, done_q, af_q, err_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       occ_q, occ_d;
    logic [CNT_W-1:0]  total_q, in_cnt_q, out_cnt_q;
    logic              push, pop, drop, last_beat, tvalid;

    // Fullness uses pre-edge occupancy, so a same-cycle pop never frees room for the push.
    assign push      = (state_q == RUN) && ofm_buffer_valid && (occ_q < DEPTH_C) && (in_cnt_q < total_q);
    assign drop      = ofm_buffer_valid && !push;
    assign tvalid    = (occ_q != '0);
    assign pop       = tvalid && m_axis_tready;
    assign last_beat = (out_cnt_q == total_q - CNT_W'(1));

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
        else if (pop && !push) occ_d = occ_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ofm_buffer_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            af_q      <= 1'b0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
            occ_q <= occ_d;
            af_q  <= (occ_d >= AF_TH);
            case (state_q)
                IDLE: if (start) begin
                    total_q   <= total_words;
                    in_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    if (total_words != '0) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                RUN: if (pop && last_beat) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A word lost on the start cycle still flags, so set takes priority over the clear.
            if (drop)                          err_q <= 1'b1;
            else if (state_q == IDLE && start) err_q <= 1'b0;
        end
    end

    assign m_axis_tvalid = tvalid;
    assign m_axis_tdata  = tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_axis_tlast  = tvalid && last_beat;
    assign almost_full   = af_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
